radix4_booth_mult: RTL and testbench

RADIX4_BOOTH_MULT -- requirements
Module: radix4_booth_mult

---
 rtl/radix4_booth_mult_if.sv | 23 ++
 rtl/radix4_booth_mult.sv | 83 ++++++++
 tb/tb_radix4_booth_mult.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/radix4_booth_mult_if.sv
// Operand/result bundle for the radix-4 Booth multiplier.
// The master issues start and operands; the slave (the multiplier) returns prd, busy and done.
interface radix4_booth_mult_if #(
   parameter int WIDTH = 8
);
   logic               start;
   logic               signed_mode;
   logic [WIDTH-1:0]   mc;
   logic [WIDTH-1:0]   mp;
   logic [2*WIDTH-1:0] prd;
   logic               busy;
   logic               done;

   modport master (
      output start, signed_mode, mc, mp,
      input  prd, busy, done
   );

   modport slave (
      input  start, signed_mode, mc, mp,
      output prd, busy, done
   );
endinterface

// File: rtl/radix4_booth_mult.sv
// Sequential radix-4 Booth multiplier that retires two multiplier bits per CALC cycle.
// Operands are widened by two bits, so signed and unsigned use the same recoding.
module radix4_booth_mult #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   radix4_booth_mult_if.slave bus
);
   localparam int EW = WIDTH + 2;
   localparam int AW = WIDTH + 4;
   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   a, m, m2, addend, a_sum, a_nxt;
   logic [EW-1:0]   q, q_nxt;
   logic            qm1;
   logic [CW-1:0]   cnt;
   logic            load, last;

   assign load     = bus.start && (state != CALC);
   assign last     = (state == CALC) && (cnt == CW'(N - 1));
   assign bus.busy = (state == CALC);
   assign bus.done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = CALC;
         CALC:    if (last) state_nxt = DONE;
         DONE:    state_nxt = load ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Recode the current bit triplet, accumulate, then shift {A,Q,Q_-1} right by two.
   always_comb begin
      m2     = {m[AW-2:0], 1'b0};
      addend = '0;
      case ({q[1:0], qm1})
         3'b001, 3'b010: addend = m;
         3'b011:         addend = m2;
         3'b100:         addend = '0 - m2;
         3'b101, 3'b110: addend = '0 - m;
         default:        addend = '0;
      endcase
      a_sum = a + addend;
      a_nxt = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
      q_nxt = {a_sum[1:0], q[EW-1:2]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a       <= '0;
         m       <= '0;
         q       <= '0;
         qm1     <= 1'b0;
         cnt     <= '0;
         bus.prd <= '0;
      end else if (load) begin
         a   <= '0;
         m   <= {{4{bus.signed_mode & bus.mc[WIDTH-1]}}, bus.mc};
         q   <= {{2{bus.signed_mode & bus.mp[WIDTH-1]}}, bus.mp};
         qm1 <= 1'b0;
         cnt <= '0;
      end else if (state == CALC) begin
         a   <= a_nxt;
         q   <= q_nxt;
         qm1 <= q[1];
         cnt <= cnt + CW'(1);
         // The product is exposed only once the final step has been applied.
         if (last) bus.prd <= {a_nxt[WIDTH-3:0], q_nxt};
      end
   end
endmodule

// File: tb/tb_radix4_booth_mult.sv
// Scoreboard bench for radix4_booth_mult at WIDTH=8 and WIDTH=16.
// Expected products come from plain integer multiplication of the operands.
module tb_radix4_booth_mult;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total  = 0;
   int   passed = 0;

   logic [15:0] exp8[$];
   logic [31:0] exp16[$];

   always #5 clk = ~clk;

   radix4_booth_mult_if #(.WIDTH(8))  bus8();
   radix4_booth_mult_if #(.WIDTH(16)) bus16();

   radix4_booth_mult #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
   radix4_booth_mult #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] ref_mult(input int w, input bit sm,
                                            input logic [15:0] x, input logic [15:0] y);
      longint xv, yv, p;
      if (w == 8) begin
         xv = sm ? longint'($signed(x[7:0])) : longint'(x[7:0]);
         yv = sm ? longint'($signed(y[7:0])) : longint'(y[7:0]);
      end else begin
         xv = sm ? longint'($signed(x)) : longint'(x);
         yv = sm ? longint'($signed(y)) : longint'(y);
      end
      p = xv * yv;
      return (w == 8) ? {16'h0, p[15:0]} : p[31:0];
   endfunction

   // Called on a negedge; waits for the DUT to accept, drives one request and pushes its expectation.
   task automatic apply_stimulus(input int w, input bit sm, input logic [15:0] x,
                                 input logic [15:0] y, input bit hold, output int waited);
      logic [31:0] e;
      waited = 1;
      while (w == 8 ? bus8.busy : bus16.busy) begin
         if (waited > 40) begin
            check_output("accept_timeout", 32'(waited), 32'd40);
            break;
         end
         @(negedge clk);
         waited++;
      end
      e = ref_mult(w, sm, x, y);
      if (w == 8) begin
         bus8.start = 1'b1; bus8.signed_mode = sm; bus8.mc = x[7:0]; bus8.mp = y[7:0];
         exp8.push_back(e[15:0]);
      end else begin
         bus16.start = 1'b1; bus16.signed_mode = sm; bus16.mc = x; bus16.mp = y;
         exp16.push_back(e);
      end
      @(negedge clk);
      if (w == 8) bus8.start = hold;
      else        bus16.start = hold;
   endtask

   task automatic run_directed(input int w, input bit sm, input logic [15:0] x,
                               input logic [15:0] y, input logic [31:0] exp);
      int waited, lat;
      apply_stimulus(w, sm, x, y, 1'b0, waited);
      check_output("busy_after_start", 32'(w == 8 ? bus8.busy : bus16.busy), 32'd1);
      lat = 1;
      while (!(w == 8 ? bus8.done : bus16.done) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_output("latency", 32'(lat), 32'(w / 2 + 2));
      check_output("prd_const", (w == 8) ? 32'(bus8.prd) : bus16.prd, exp);
      check_output("busy_in_done", 32'(w == 8 ? bus8.busy : bus16.busy), 32'd0);
      @(negedge clk);
      check_output("done_single_pulse", 32'(w == 8 ? bus8.done : bus16.done), 32'd0);
      check_output("prd_hold", (w == 8) ? 32'(bus8.prd) : bus16.prd, exp);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus8.done) begin
         check_output("pending8", 32'(exp8.size() > 0), 32'd1);
         if (exp8.size() > 0) check_output("prd8", 32'(bus8.prd), 32'(exp8.pop_front()));
      end
      if (!rst && bus16.done) begin
         check_output("pending16", 32'(exp16.size() > 0), 32'd1);
         if (exp16.size() > 0) check_output("prd16", bus16.prd, exp16.pop_front());
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waited;
      logic [15:0] b2b_mc[6] = '{16'h80, 16'hFF, 16'h7F, 16'h01, 16'hC3, 16'h00};
      logic [15:0] b2b_mp[6] = '{16'h80, 16'hFF, 16'h81, 16'hFF, 16'h5A, 16'h9E};

      bus8.start = 0;  bus8.signed_mode = 0;  bus8.mc = 0;  bus8.mp = 0;
      bus16.start = 0; bus16.signed_mode = 0; bus16.mc = 0; bus16.mp = 0;
      #1;
      check_output("reset_prd8", 32'(bus8.prd), 32'd0);
      check_output("reset_busy8", 32'(bus8.busy), 32'd0);
      check_output("reset_done8", 32'(bus8.done), 32'd0);
      check_output("reset_prd16", bus16.prd, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] directed corner products");
      run_directed(8, 1'b1, 16'h80, 16'h80, 32'h4000);
      run_directed(8, 1'b0, 16'hFF, 16'hFF, 32'hFE01);
      run_directed(8, 1'b1, 16'hFF, 16'hFF, 32'h0001);
      run_directed(16, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
      run_directed(16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

      $display("[TB] start ignored during CALC");
      apply_stimulus(8, 1'b1, 16'h07, 16'hFD, 1'b0, waited);
      @(negedge clk);
      bus8.start = 1'b1; bus8.mc = 8'h02; bus8.mp = 8'h02;
      @(negedge clk);
      bus8.start = 1'b0;
      waited = 0;
      while (!bus8.done && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check_output("ignored_start_prd", 32'(bus8.prd), 32'hFFEB);
      @(negedge clk);

      $display("[TB] reset during CALC");
      bus8.start = 1'b1; bus8.signed_mode = 1'b1; bus8.mc = 8'h55; bus8.mp = 8'h33;
      @(negedge clk);
      bus8.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("abort_busy", 32'(bus8.busy), 32'd0);
      check_output("abort_done", 32'(bus8.done), 32'd0);
      check_output("abort_prd", 32'(bus8.prd), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_output("abort_prd_after", 32'(bus8.prd), 32'd0);
      run_directed(8, 1'b1, 16'h03, 16'h04, 32'h000C);

      $display("[TB] back-to-back with start held");
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(8, i[0], b2b_mc[i], b2b_mp[i], 1'b1, waited);
         if (i > 0) check_output("b2b_period", 32'(waited), 32'd6);
      end
      bus8.start = 1'b0;
      repeat (10) @(negedge clk);

      $display("[TB] random sweep");
      fork
         begin
            int w8;
            for (int i = 0; i < 3000; i++) begin
               apply_stimulus(8, 1'($urandom), 16'($urandom), 16'($urandom), 1'b1, w8);
               if (i > 0 && w8 != 6) check_output("sweep8_period", 32'(w8), 32'd6);
            end
            bus8.start = 1'b0;
         end
         begin
            int w16;
            for (int i = 0; i < 3000; i++) begin
               apply_stimulus(16, 1'($urandom), 16'($urandom), 16'($urandom), 1'b1, w16);
               if (i > 0 && w16 != 10) check_output("sweep16_period", 32'(w16), 32'd10);
            end
            bus16.start = 1'b0;
         end
      join
      repeat (15) @(negedge clk);

      check_output("queue8_drained", 32'(exp8.size()), 32'd0);
      check_output("queue16_drained", 32'(exp16.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
